// File: rtl/trig_sched_pkg.sv
// Shared definitions for the trigger scheduler: command codes, state/mode enums
// and the command decode helpers.
package trig_sched_pkg;

    localparam logic [3:0] CMD_STOP    = 4'b0000;
    localparam logic [3:0] CMD_SINGLE0 = 4'b0001;
    localparam logic [3:0] CMD_SINGLE1 = 4'b0010;
    localparam logic [3:0] CMD_SINGLE2 = 4'b0111;
    localparam logic [3:0] CMD_CONT    = 4'b0100;
    localparam logic [3:0] CMD_BURST   = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;
    typedef enum logic [1:0] {M_SINGLE, M_CONT, M_BURST} mode_e;
    typedef enum logic [2:0] {K_STOP, K_SINGLE, K_CONT, K_BURST, K_INVALID} kind_e;

    function automatic logic is_single(input logic [3:0] cmd);
        return (cmd == CMD_SINGLE0) || (cmd == CMD_SINGLE1) || (cmd == CMD_SINGLE2);
    endfunction

    function automatic kind_e decode_cmd(input logic [3:0] cmd);
        kind_e k;
        if (cmd == CMD_STOP)       k = K_STOP;
        else if (is_single(cmd))   k = K_SINGLE;
        else if (cmd == CMD_CONT)  k = K_CONT;
        else if (cmd == CMD_BURST) k = K_BURST;
        else                       k = K_INVALID;
        return k;
    endfunction

endpackage

// File: rtl/trig_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves only when a
// grant is taken, and nothing is granted while en is low.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_vld,
    input  logic b_vld,
    output logic gnt_a,
    output logic gnt_b,
    output logic xfer
);

    logic prio_b;

    assign gnt_a = en & a_vld & (~b_vld | ~prio_b);
    assign gnt_b = en & b_vld & (~a_vld |  prio_b);
    assign xfer  = gnt_a | gnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (gnt_a) begin
            prio_b <= 1'b1;
        end else if (gnt_b) begin
            prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/trig_sched.sv
// Trigger scheduler: arbitrates two command ports and sequences single, continuous
// or burst pulses on trig. Define TRIG_SCHED_ERRCNT_EN to add the err_cnt output.
//
// state  | meaning
// S_IDLE | no sequence running, both ports may be granted
// S_HIGH | trig high, cnt counts the remaining high cycles
// S_LOW  | trig low between pulses, cnt counts the remaining low cycles
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter int CW     = 28,
    parameter int BW     = 8,
    parameter int PW_MIN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_vld,
    input  logic [3:0]    a_cmd,
    output logic          a_rdy,
    input  logic          b_vld,
    input  logic [3:0]    b_cmd,
    output logic          b_rdy,
    input  logic [CW-1:0] cfg_pw,
    input  logic [CW-1:0] cfg_per,
    input  logic [BW-1:0] cfg_burst,
    output logic          trig,
    output logic          busy,
    output logic          done,
`ifdef TRIG_SCHED_ERRCNT_EN
    output logic [7:0]    err_cnt,
`endif
    output logic          grant_b
);

    state_e        state;
    mode_e         mode;
    logic [CW-1:0] cnt;
    logic [BW-1:0] burst_rem;
    logic [CW-1:0] pw_sh;
    logic [CW-1:0] low_sh;

    logic          window;
    logic          xfer;
    logic [3:0]    cmd;
    kind_e         kind;
    logic          start;
    mode_e         new_mode;
    logic [CW-1:0] pw_eff;
    logic [CW:0]   pw_inc;
    logic [CW:0]   per_eff;
    logic [CW-1:0] low_eff;
    logic [BW-1:0] burst_eff;

    // A running SINGLE cannot be interrupted, so it closes the acceptance window.
    assign window = (state == S_IDLE) || (mode != M_SINGLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (window),
        .a_vld (a_vld),
        .b_vld (b_vld),
        .gnt_a (a_rdy),
        .gnt_b (b_rdy),
        .xfer  (xfer)
    );

    assign cmd   = b_rdy ? b_cmd : a_cmd;
    assign kind  = decode_cmd(cmd);
    assign start = xfer && (kind inside {K_SINGLE, K_CONT, K_BURST});
    assign busy  = (state != S_IDLE);

    always_comb begin
        new_mode = M_SINGLE;
        case (kind)
            K_CONT:  new_mode = M_CONT;
            K_BURST: new_mode = M_BURST;
            default: new_mode = M_SINGLE;
        endcase
    end

    // One extra bit on the period path so pw_eff+1 cannot overflow at max cfg_pw.
    assign pw_eff    = (cfg_pw < CW'(PW_MIN)) ? CW'(PW_MIN) : cfg_pw;
    assign pw_inc    = {1'b0, pw_eff} + (CW+1)'(1);
    assign per_eff   = ({1'b0, cfg_per} < pw_inc) ? pw_inc : {1'b0, cfg_per};
    assign low_eff   = CW'(per_eff - {1'b0, pw_eff} - (CW+1)'(1));
    assign burst_eff = (cfg_burst == '0) ? BW'(1) : cfg_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode      <= M_SINGLE;
            cnt       <= '0;
            burst_rem <= '0;
            pw_sh     <= '0;
            low_sh    <= '0;
            trig      <= 1'b0;
            done      <= 1'b0;
            grant_b   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer) begin
                grant_b <= b_rdy;
            end
            if (start) begin
                state     <= S_HIGH;
                trig      <= 1'b1;
                mode      <= new_mode;
                cnt       <= pw_eff - CW'(1);
                pw_sh     <= pw_eff;
                low_sh    <= low_eff;
                burst_rem <= (new_mode == M_BURST) ? burst_eff - BW'(1) : '0;
            end else if (xfer && kind == K_STOP) begin
                state     <= S_IDLE;
                trig      <= 1'b0;
                cnt       <= '0;
                burst_rem <= '0;
            end else begin
                case (state)
                    S_HIGH: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (mode == M_SINGLE ||
                                     (mode == M_BURST && burst_rem == '0)) begin
                            state <= S_IDLE;
                            trig  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOW;
                            trig  <= 1'b0;
                            cnt   <= low_sh;
                        end
                    end
                    S_LOW: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state <= S_HIGH;
                            trig  <= 1'b1;
                            cnt   <= pw_sh - CW'(1);
                            if (mode == M_BURST) begin
                                burst_rem <= burst_rem - BW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        trig  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TRIG_SCHED_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (xfer && kind == K_INVALID && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: a per-cycle vector table plus hand-written
// sequences for continuous, burst, clamp, arbitration and reset cases.
module tb_trig_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_vld, b_vld;
    logic [3:0]  a_cmd, b_cmd;
    logic        a_rdy, b_rdy;
    logic [27:0] cfg_pw, cfg_per;
    logic [7:0]  cfg_burst;
    logic        trig, busy, done, grant_b;
`ifdef TRIG_SCHED_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trig_sched dut (
        .clk       (clk),
        .rst       (rst),
        .a_vld     (a_vld),
        .a_cmd     (a_cmd),
        .a_rdy     (a_rdy),
        .b_vld     (b_vld),
        .b_cmd     (b_cmd),
        .b_rdy     (b_rdy),
        .cfg_pw    (cfg_pw),
        .cfg_per   (cfg_per),
        .cfg_burst (cfg_burst),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
`ifdef TRIG_SCHED_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .grant_b   (grant_b)
    );

    // Per-cycle vector; exp = {trig, busy, done, grant_b, a_rdy, b_rdy}
    typedef struct {
        logic        a_vld;
        logic [3:0]  a_cmd;
        logic        b_vld;
        logic [3:0]  b_cmd;
        logic [27:0] pw;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_vld = 1'b0; b_vld = 1'b0; a_cmd = 4'h0; b_cmd = 4'h0;
        cfg_pw = 28'd0; cfg_per = 28'd0; cfg_burst = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd4, 6'b000000};
        vecs[1]  = '{1'b1, 4'h1, 1'b0, 4'h0, 28'd4, 6'b000010};
        vecs[2]  = '{1'b1, 4'h4, 1'b0, 4'h0, 28'd4, 6'b110000};
        vecs[3]  = '{1'b1, 4'h4, 1'b1, 4'hF, 28'd4, 6'b110000};
        vecs[4]  = '{1'b1, 4'h4, 1'b0, 4'h0, 28'd4, 6'b110000};
        vecs[5]  = '{1'b1, 4'h4, 1'b0, 4'h0, 28'd4, 6'b110000};
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd4, 6'b001000};
        vecs[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd4, 6'b000000};
        vecs[8]  = '{1'b0, 4'h0, 1'b1, 4'hF, 28'd4, 6'b000001};
        vecs[9]  = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd4, 6'b000100};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 4'h0, 28'd4, 6'b000101};
        vecs[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd4, 6'b000100};
        vecs[12] = '{1'b1, 4'h7, 1'b0, 4'h0, 28'd0, 6'b000110};
        vecs[13] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd0, 6'b110000};
        vecs[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd0, 6'b001000};
        vecs[15] = '{1'b1, 4'h2, 1'b1, 4'h2, 28'd1, 6'b000001};
        vecs[16] = '{1'b1, 4'h2, 1'b0, 4'h0, 28'd1, 6'b110100};
        vecs[17] = '{1'b1, 4'h2, 1'b0, 4'h0, 28'd1, 6'b001110};
        vecs[18] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd1, 6'b110000};
        vecs[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd1, 6'b001000};
        vecs[20] = '{1'b0, 4'h0, 1'b0, 4'h0, 28'd1, 6'b000000};

        do_reset();
        for (int r = 0; r < 21; r++) begin
            @(negedge clk);
            a_vld = vecs[r].a_vld; a_cmd = vecs[r].a_cmd;
            b_vld = vecs[r].b_vld; b_cmd = vecs[r].b_cmd;
            cfg_pw = vecs[r].pw; cfg_per = 28'd0; cfg_burst = 8'd0;
            #1;
            chk($sformatf("vec%0d", r), {26'd0, trig, busy, done, grant_b, a_rdy, b_rdy},
                {26'd0, vecs[r].exp});
        end

        // Continuous from B, period 10 high 3, truncated by STOP from A.
        do_reset();
        @(negedge clk);
        b_vld = 1'b1; b_cmd = 4'h4; cfg_pw = 28'd3; cfg_per = 28'd10;
        #1 chk("cont_b_rdy", b_rdy, 1);
        for (int i = 0; i <= 21; i++) begin
            @(negedge clk);
            b_vld = 1'b0; cfg_pw = 28'd1; cfg_per = 28'd3;
            if (i == 21) begin
                a_vld = 1'b1; a_cmd = 4'h0;
            end
            #1;
            chk($sformatf("cont_c%0d", i), {trig, busy, done}, {1'((i % 10) < 3), 2'b10});
            if (i == 21) chk("stop_a_rdy", a_rdy, 1);
        end
        @(negedge clk);
        a_vld = 1'b0;
        #1 chk("stop_idle", {trig, busy, done}, 3'b000);
        @(negedge clk);
        #1 chk("stop_no_done", done, 0);

        // Burst of 3, pw 2, period 5; config changes after accept must not matter.
        @(negedge clk);
        a_vld = 1'b1; a_cmd = 4'h8; cfg_pw = 28'd2; cfg_per = 28'd5; cfg_burst = 8'd3;
        #1 chk("burst_a_rdy", a_rdy, 1);
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            a_vld = 1'b0; cfg_pw = 28'd4; cfg_burst = 8'd9;
            #1;
            chk($sformatf("burst_c%0d", i), {trig, busy, done},
                {1'(i inside {0, 1, 5, 6, 10, 11}), 1'(i <= 11), 1'(i == 12)});
        end

        // Both requesters hold SINGLE from reset: A first, then B.
        do_reset();
        @(negedge clk);
        a_vld = 1'b1; a_cmd = 4'h1; b_vld = 1'b1; b_cmd = 4'h1; cfg_pw = 28'd2;
        #1 chk("rr_c0", {grant_b, a_rdy, b_rdy}, 3'b010);
        @(negedge clk);
        a_vld = 1'b0;
        #1 chk("rr_c1", {trig, grant_b, a_rdy, b_rdy}, 4'b1000);
        @(negedge clk);
        #1 chk("rr_c2", {trig, grant_b, a_rdy, b_rdy}, 4'b1000);
        @(negedge clk);
        #1 chk("rr_c3", {trig, done, grant_b, a_rdy, b_rdy}, 5'b01001);
        @(negedge clk);
        b_vld = 1'b0;
        #1 chk("rr_c4", {trig, grant_b}, 2'b11);
        @(negedge clk);
        #1 chk("rr_c5", trig, 1);
        @(negedge clk);
        a_vld = 1'b1; a_cmd = 4'hF; b_vld = 1'b1; b_cmd = 4'hF;
        #1 chk("rr_c6", {done, a_rdy, b_rdy}, 3'b110);
        @(negedge clk);
        #1 chk("rr_c7", {grant_b, a_rdy, b_rdy}, 3'b001);
        @(negedge clk);
        a_vld = 1'b0; b_vld = 1'b0;
        #1 chk("rr_c8", {grant_b, busy}, 2'b10);

        // Clamps: pw 5 per 2 -> high 5 low 1; then preempt with pw 0 -> 1-cycle pulses.
        @(negedge clk);
        b_vld = 1'b1; b_cmd = 4'h4; cfg_pw = 28'd5; cfg_per = 28'd2;
        #1 chk("clamp_b_rdy", b_rdy, 1);
        for (int i = 0; i <= 13; i++) begin
            @(negedge clk);
            b_vld = 1'b0;
            if (i == 13) begin
                a_vld = 1'b1; a_cmd = 4'h4; cfg_pw = 28'd0; cfg_per = 28'd0;
            end
            #1;
            chk($sformatf("clamp_c%0d", i), {trig, busy, done}, {1'((i % 6) < 5), 2'b10});
            if (i == 13) chk("preempt_a_rdy", a_rdy, 1);
        end
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            a_vld = 1'b0;
            #1;
            chk($sformatf("pw0_c%0d", j), {trig, busy, done}, {1'((j % 2) == 0), 2'b10});
        end
        @(negedge clk);
        b_vld = 1'b1; b_cmd = 4'h0;
        #1 chk("pw0_stop_rdy", b_rdy, 1);
        @(negedge clk);
        b_vld = 1'b0;
        #1 chk("pw0_stopped", {trig, busy, done}, 3'b000);

        // Reset in the middle of a long HIGH phase.
        @(negedge clk);
        b_vld = 1'b1; b_cmd = 4'h1; cfg_pw = 28'd10;
        @(negedge clk);
        b_vld = 1'b0;
        @(negedge clk);
        #1 chk("midrst_pre", {trig, busy, grant_b}, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_post", {trig, busy, done, grant_b}, 4'b0000);

`ifdef TRIG_SCHED_ERRCNT_EN
        do_reset();
        #1 chk("err_reset", err_cnt, 0);
        b_vld = 1'b1; b_cmd = 4'hF;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            #1;
            if (k == 3 || k == 254 || k == 255 || k == 300)
                chk($sformatf("err_k%0d", k), err_cnt, (k < 255) ? k : 255);
        end
        b_vld = 1'b0;
        #1 chk("err_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
